// File: rtl/bcd_field_counter.sv
// Up/down BCD counter for one RTC date/time field, with wrap pulses for cascading.
// Define BCD_FIELD_AUTOREPEAT_EN to enable hold-to-repeat stepping.
module bcd_field_counter #(
  parameter int MIN_VAL       = 0,
  parameter int MAX_VAL       = 99,
  parameter int DIGITS        = 2,
  parameter int FIELD_ID      = 4,
  parameter int SEL_W         = 4,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10,
  localparam int N = (MAX_VAL < 1) ? 1 : $clog2(MAX_VAL + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SEL_W-1:0]      en_count,
  input  logic                  enUP,
  input  logic                  enDOWN,
  input  logic                  load,
  input  logic [N-1:0]          load_val,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  wrap_up,
  output logic                  wrap_down
);

  localparam logic [N-1:0]     MIN_C   = N'(MIN_VAL);
  localparam logic [N-1:0]     MAX_C   = N'(MAX_VAL);
  localparam logic [SEL_W-1:0] FIELD_C = SEL_W'(FIELD_ID);

  generate
    if (MIN_VAL < 0 || MIN_VAL > MAX_VAL || DIGITS < 1 || DIGITS > 3 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
      $error("bcd_field_counter: illegal parameter combination");
    end
  endgenerate

  logic [N-1:0] count_q, count_d;
  logic         en_up_q, en_dn_q;
  logic         up_blk_q, dn_blk_q;
  logic         wrap_up_q, wrap_up_d, wrap_dn_q, wrap_dn_d;
  logic         sel, up_tick, dn_tick, step_up, step_dn;
  logic         ge_min, le_max;
  logic         rpt_up, rpt_dn;

  // Range limits that span the whole binary width would be constant compares.
  generate
    if (MIN_VAL == 0) begin : g_ge_min_true
      assign ge_min = 1'b1;
    end else begin : g_ge_min_cmp
      assign ge_min = (load_val >= MIN_C);
    end
    if (MAX_VAL == (2**N) - 1) begin : g_le_max_true
      assign le_max = 1'b1;
    end else begin : g_le_max_cmp
      assign le_max = (load_val <= MAX_C);
    end
  endgenerate

  assign sel = (en_count == FIELD_C);
  // A button already held across reset is blocked until released, so it cannot step on reset exit.
  assign up_tick = enUP & ~en_up_q & ~up_blk_q;
  assign dn_tick = enDOWN & ~en_dn_q & ~dn_blk_q;
  assign step_up = sel & ((up_tick & ~dn_tick) | rpt_up);
  assign step_dn = sel & ((dn_tick & ~up_tick) | rpt_dn);

`ifdef BCD_FIELD_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW      = $clog2(RPT_MAX + 1);
  localparam logic [TW-1:0] DELAY_C  = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0] PERIOD_C = TW'(REPEAT_PERIOD);

  logic [TW-1:0] rpt_q, rpt_d;
  logic          first_q, first_d;
  logic          hold_up, hold_dn, hold, fire;

  assign hold_up = sel & enUP & ~enDOWN & ~up_blk_q;
  assign hold_dn = sel & enDOWN & ~enUP & ~dn_blk_q;
  assign hold    = hold_up | hold_dn;
  assign fire    = hold & ~up_tick & ~dn_tick &
                   (rpt_q == (first_q ? DELAY_C : PERIOD_C));
  assign rpt_up  = fire & hold_up;
  assign rpt_dn  = fire & hold_dn;

  always_comb begin
    rpt_d   = rpt_q;
    first_d = first_q;
    if (load || !hold) begin
      rpt_d   = '0;
      first_d = 1'b1;
    end else if (up_tick || dn_tick) begin
      rpt_d   = TW'(1);
      first_d = 1'b1;
    end else if (fire) begin
      rpt_d   = TW'(1);
      first_d = 1'b0;
    end else begin
      rpt_d = rpt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      rpt_q   <= rpt_d;
      first_q <= first_d;
    end
  end
`else
  assign rpt_up = 1'b0;
  assign rpt_dn = 1'b0;
`endif

  // An out-of-range load is dropped but still swallows any step in that cycle.
  always_comb begin
    count_d   = count_q;
    wrap_up_d = 1'b0;
    wrap_dn_d = 1'b0;
    if (load) begin
      if (ge_min && le_max) begin
        count_d = load_val;
      end
    end else if (step_up) begin
      if (count_q == MAX_C) begin
        count_d   = MIN_C;
        wrap_up_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (step_dn) begin
      if (count_q == MIN_C) begin
        count_d   = MAX_C;
        wrap_dn_d = 1'b1;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= MIN_C;
      en_up_q   <= 1'b0;
      en_dn_q   <= 1'b0;
      up_blk_q  <= enUP;
      dn_blk_q  <= enDOWN;
      wrap_up_q <= 1'b0;
      wrap_dn_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      en_up_q   <= enUP;
      en_dn_q   <= enDOWN;
      up_blk_q  <= up_blk_q & enUP;
      dn_blk_q  <= dn_blk_q & enDOWN;
      wrap_up_q <= wrap_up_d;
      wrap_dn_q <= wrap_dn_d;
    end
  end

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_bcd
      localparam int unsigned DIV = 10**gi;
      assign digits[4*gi +: 4] = 4'((32'(count_q) / DIV) % 32'd10);
    end
  endgenerate

  assign wrap_up   = wrap_up_q;
  assign wrap_down = wrap_dn_q;

endmodule

// File: tb/tb_bcd_field_counter.sv
// Directed bench for bcd_field_counter: a 0..99 field, a 1..12 field and a fast-repeat field.
// Repeat expectations follow BCD_FIELD_AUTOREPEAT_EN when it is defined.
module tb_bcd_field_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] en_count = 4'd4;

  logic       a_up = 1'b0, a_dn = 1'b0, a_load = 1'b0;
  logic [6:0] a_load_val = '0;
  logic [7:0] a_digits;
  logic       a_wu, a_wd;

  logic       b_up = 1'b0, b_dn = 1'b0, b_load = 1'b0;
  logic [3:0] b_load_val = '0;
  logic [7:0] b_digits;
  logic       b_wu, b_wd;

  logic       c_up = 1'b0, c_dn = 1'b0, c_load = 1'b0;
  logic [6:0] c_load_val = '0;
  logic [7:0] c_digits;
  logic       c_wu, c_wd;

  int n_checks = 0;
  int n_errors = 0;
  int exp_rep[10];
  int exp_final;

  always #5 clk = ~clk;

  bcd_field_counter u_a (
    .clk(clk), .reset(reset), .en_count(en_count), .enUP(a_up), .enDOWN(a_dn),
    .load(a_load), .load_val(a_load_val), .digits(a_digits), .wrap_up(a_wu), .wrap_down(a_wd)
  );

  bcd_field_counter #(.MIN_VAL(1), .MAX_VAL(12)) u_b (
    .clk(clk), .reset(reset), .en_count(en_count), .enUP(b_up), .enDOWN(b_dn),
    .load(b_load), .load_val(b_load_val), .digits(b_digits), .wrap_up(b_wu), .wrap_down(b_wd)
  );

  bcd_field_counter #(.REPEAT_DELAY(4), .REPEAT_PERIOD(2)) u_c (
    .clk(clk), .reset(reset), .en_count(en_count), .enUP(c_up), .enDOWN(c_dn),
    .load(c_load), .load_val(c_load_val), .digits(c_digits), .wrap_up(c_wu), .wrap_down(c_wd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
`ifdef BCD_FIELD_AUTOREPEAT_EN
    exp_rep   = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4};
    exp_final = 4;
`else
    exp_rep   = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    exp_final = 1;
`endif

    // T1 reset
    cyc(2);
    check("T1 a digits", a_digits, 8'h00);
    check("T1 a wrap_up", a_wu, 0);
    check("T1 a wrap_down", a_wd, 0);
    check("T1 b digits", b_digits, 8'h01);
    reset = 1'b0;
    cyc(1);

    // T2 one step per press, none while held
    for (int p = 1; p <= 3; p++) begin
      a_up = 1'b1;
      cyc(1);
      check("T2 step", a_digits, p);
      cyc(4);
      check("T2 held", a_digits, p);
      a_up = 1'b0;
      cyc(2);
    end
    check("T2 final", a_digits, 8'h03);

    // T3 load 99, wrap up and down
    a_load = 1'b1; a_load_val = 7'd99;
    cyc(1);
    a_load = 1'b0;
    check("T3 load99", a_digits, 8'h99);
    a_up = 1'b1;
    cyc(1);
    check("T3 wrap digits", a_digits, 8'h00);
    check("T3 wrap_up", a_wu, 1);
    check("T3 no wrap_down", a_wd, 0);
    cyc(1);
    check("T3 wrap_up pulse end", a_wu, 0);
    a_up = 1'b0;
    cyc(1);
    a_dn = 1'b1;
    cyc(1);
    check("T3 down wrap digits", a_digits, 8'h99);
    check("T3 wrap_down", a_wd, 1);
    check("T3 no wrap_up", a_wu, 0);
    cyc(1);
    check("T3 wrap_down pulse end", a_wd, 0);
    a_dn = 1'b0;
    cyc(1);
    // out-of-range load swallows the step in the same cycle
    a_load = 1'b1; a_load_val = 7'd120; a_up = 1'b1;
    cyc(1);
    a_load = 1'b0;
    check("T3 bad load", a_digits, 8'h99);
    check("T3 bad load no wrap", a_wu, 0);
    cyc(1);
    check("T3 bad load held", a_digits, 8'h99);
    a_up = 1'b0;
    cyc(1);
    a_load = 1'b1; a_load_val = 7'd47;
    cyc(1);
    a_load = 1'b0;
    check("T3 load47", a_digits, 8'h47);
    a_dn = 1'b1;
    cyc(1);
    check("T3 dec47", a_digits, 8'h46);
    a_dn = 1'b0;
    cyc(1);

    // T4 month-style field 1..12
    check("T4 start", b_digits, 8'h01);
    b_dn = 1'b1;
    cyc(1);
    check("T4 wrap to 12", b_digits, 8'h12);
    check("T4 wrap_down", b_wd, 1);
    b_dn = 1'b0;
    cyc(1);
    check("T4 wrap_down end", b_wd, 0);
    b_load = 1'b1; b_load_val = 4'd13;
    cyc(1);
    b_load = 1'b0;
    check("T4 load13 ignored", b_digits, 8'h12);
    b_up = 1'b1; b_dn = 1'b1;
    cyc(1);
    check("T4 both digits", b_digits, 8'h12);
    check("T4 both wrap_up", b_wu, 0);
    check("T4 both wrap_down", b_wd, 0);
    b_up = 1'b0; b_dn = 1'b0;
    cyc(1);
    b_up = 1'b1;
    cyc(1);
    check("T4 12 to 1", b_digits, 8'h01);
    check("T4 wrap_up", b_wu, 1);
    b_up = 1'b0;
    cyc(1);
    b_load = 1'b1; b_load_val = 4'd0;
    cyc(1);
    b_load = 1'b0;
    check("T4 load0 ignored", b_digits, 8'h01);
    b_load = 1'b1; b_load_val = 4'd9;
    cyc(1);
    b_load = 1'b0;
    b_up = 1'b1;
    cyc(1);
    check("T4 9 to 10", b_digits, 8'h10);
    b_up = 1'b0;
    cyc(1);

    // T5 deselected field ignores presses; selecting mid-hold gives no step
    en_count = 4'd3;
    for (int p = 0; p < 4; p++) begin
      a_up = 1'b1;
      cyc(1);
      a_up = 1'b0;
      cyc(1);
    end
    check("T5 deselected", a_digits, 8'h46);
    a_up = 1'b1;
    cyc(1);
    en_count = 4'd4;
    cyc(3);
    check("T5 select mid-hold", a_digits, 8'h46);
    a_up = 1'b0;
    cyc(1);
    a_up = 1'b1;
    cyc(1);
    check("T5 next edge", a_digits, 8'h47);
    a_up = 1'b0;
    cyc(1);

    // T6 hold for 10 cycles on the fast-repeat instance
    check("T6 start", c_digits, 8'h00);
    c_up = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      check($sformatf("T6 hold cycle %0d", k + 1), c_digits, exp_rep[k]);
    end
    c_up = 1'b0;
    cyc(1);
    check("T6 final", c_digits, exp_final);

    // T7 reset during a hold at 57
    a_up = 1'b1;
    cyc(1);
    a_load = 1'b1; a_load_val = 7'd57;
    cyc(1);
    a_load = 1'b0;
    check("T7 load57", a_digits, 8'h57);
    cyc(2);
    check("T7 held", a_digits, 8'h57);
    reset = 1'b1;
    cyc(1);
    check("T7 reset digits", a_digits, 8'h00);
    check("T7 reset b", b_digits, 8'h01);
    reset = 1'b0;
    cyc(3);
    check("T7 held after reset", a_digits, 8'h00);
    a_up = 1'b0;
    cyc(1);
    a_up = 1'b1;
    cyc(1);
    check("T7 re-press", a_digits, 8'h01);
    a_up = 1'b0;
    cyc(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
